// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared definitions for the pipeline hazard controller.
//            FSM state encoding, the hard-wired zero register index, and
//            the load-use hazard decode function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Load in EX whose destination feeds a source of the instruction in ID.
  // A load into $zero never creates a real dependency.
  function automatic logic load_use(input logic       mem_read,
                                    input logic [4:0] ex_rt,
                                    input logic [4:0] id_rs,
                                    input logic [4:0] id_rt);
    return mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Purpose  : W-bit up-counter that sticks at all-ones instead of wrapping.
// Ports    : clk   - clock, rising edge
//            rst_n - asynchronous active-low reset, clears count
//            en    - count this cycle
//            clear - synchronous clear, wins over en
//            count - current value
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clear,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] C_MAX = {W{1'b1}};
  localparam logic [W-1:0] C_ONE = W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != C_MAX)) begin
      count <= count + C_ONE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline sequencing controller for the 5-stage CPU.
//            Inserts a one-cycle ID/EX bubble on load-use hazards, flushes
//            IF/ID on taken branches/jumps, freezes the pipeline while data
//            memory has not acknowledged, counts stalls and flushes, and
//            flags a sticky memory timeout.
// Ports    : clk_i, rst_i (async, active-low)
//            IDEX_MemRead_i, IDEX_RTaddr_i, IFID_RSaddr_i, IFID_RTaddr_i
//                                  - load-use hazard inputs
//            Branch_i              - taken branch/jump resolved in ID
//            mem_req_i, mem_ack_i  - data memory handshake
//            PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXFlush_o, pipe_hold_o
//                                  - combinational pipeline controls
//            stall_cnt_o, flush_cnt_o - saturating performance counters
//            timeout_err_o         - sticky memory wait timeout
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RTaddr_i,
  input  logic [4:0]       IFID_RSaddr_i,
  input  logic [4:0]       IFID_RTaddr_i,
  input  logic             Branch_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IFIDFlush_o,
  output logic             IDEXFlush_o,
  output logic             pipe_hold_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             timeout_err_o
);

  import hazard_pkg::*;

  // Wait counter only needs to reach MEM_TIMEOUT; it parks there afterwards.
  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              miss;
  logic              frozen;
  logic              lu;

  assign miss   = mem_req_i && !mem_ack_i;
  // The ack cycle of MEM_WAIT is not frozen: the pipeline advances in it.
  assign frozen = miss || ((state == MEM_WAIT) && !mem_ack_i);
  assign lu     = load_use(IDEX_MemRead_i, IDEX_RTaddr_i,
                           IFID_RSaddr_i, IFID_RTaddr_i);

  // Priority: freeze > branch > load-use. A branch squashes the consumer in
  // ID, so a simultaneous load-use needs no bubble.
  always_comb begin
    PCWrite_o   = 1'b1;
    IFIDWrite_o = 1'b1;
    IFIDFlush_o = 1'b0;
    IDEXFlush_o = 1'b0;
    pipe_hold_o = 1'b0;
    if (frozen) begin
      pipe_hold_o = 1'b1;
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
    end else if (Branch_i) begin
      IFIDFlush_o = 1'b1;
    end else if (lu) begin
      PCWrite_o   = 1'b0;
      IFIDWrite_o = 1'b0;
      IDEXFlush_o = 1'b1;
    end
  end

  // FSM, wait counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state         <= RUN;
      wait_cnt      <= '0;
      timeout_err_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (miss) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ack_i) begin
            state <= RUN;
          end
          if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + WAIT_ONE;
          end
          // Flag is set on the edge where wait_cnt reaches MEM_TIMEOUT.
          if (wait_cnt == WAIT_LAST) begin
            timeout_err_o <= 1'b1;
          end
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (!PCWrite_o),
    .clear (1'b0),
    .count (stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .en    (IFIDFlush_o),
    .clear (1'b0),
    .count (flush_cnt_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl (CNT_W=8, MEM_TIMEOUT=4).
//            Expected control vectors are queued as stimulus is applied and
//            popped when the combinational outputs are sampled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int CNT_W = 8;

  // Control vector order: {PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, hold}
  localparam logic [4:0] NORM = 5'b11000;
  localparam logic [4:0] LU   = 5'b00010;
  localparam logic [4:0] BR   = 5'b11100;
  localparam logic [4:0] FRZ  = 5'b00001;

  typedef struct packed {
    logic       mr;
    logic [4:0] ert;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       br;
    logic       req;
    logic       ack;
    logic [4:0] ev;
  } stim_t;

  typedef struct {
    string      name;
    logic [4:0] v;
  } exp_t;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             IDEX_MemRead_i = 1'b0;
  logic [4:0]       IDEX_RTaddr_i = 5'd0;
  logic [4:0]       IFID_RSaddr_i = 5'd0;
  logic [4:0]       IFID_RTaddr_i = 5'd0;
  logic             Branch_i = 1'b0;
  logic             mem_req_i = 1'b0;
  logic             mem_ack_i = 1'b0;
  logic             PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXFlush_o, pipe_hold_o;
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
  logic             timeout_err_o;
  logic [4:0]       ctrl;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  assign ctrl = {PCWrite_o, IFIDWrite_o, IFIDFlush_o, IDEXFlush_o, pipe_hold_o};

  always #5 clk_i = ~clk_i;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .IDEX_MemRead_i (IDEX_MemRead_i),
    .IDEX_RTaddr_i  (IDEX_RTaddr_i),
    .IFID_RSaddr_i  (IFID_RSaddr_i),
    .IFID_RTaddr_i  (IFID_RTaddr_i),
    .Branch_i       (Branch_i),
    .mem_req_i      (mem_req_i),
    .mem_ack_i      (mem_ack_i),
    .PCWrite_o      (PCWrite_o),
    .IFIDWrite_o    (IFIDWrite_o),
    .IFIDFlush_o    (IFIDFlush_o),
    .IDEXFlush_o    (IDEXFlush_o),
    .pipe_hold_o    (pipe_hold_o),
    .stall_cnt_o    (stall_cnt_o),
    .flush_cnt_o    (flush_cnt_o),
    .timeout_err_o  (timeout_err_o)
  );

  function automatic stim_t mk(input logic mr, input logic [4:0] ert,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic br, input logic req, input logic ack,
                               input logic [4:0] ev);
    stim_t s;
    s.mr = mr; s.ert = ert; s.rs = rs; s.rt = rt;
    s.br = br; s.req = req; s.ack = ack; s.ev = ev;
    return s;
  endfunction

  // Apply one cycle of inputs and queue the control vector they must produce.
  task automatic drive(input string name, input stim_t s);
    exp_t e;
    IDEX_MemRead_i = s.mr;
    IDEX_RTaddr_i  = s.ert;
    IFID_RSaddr_i  = s.rs;
    IFID_RTaddr_i  = s.rt;
    Branch_i       = s.br;
    mem_req_i      = s.req;
    mem_ack_i      = s.ack;
    e.name = name;
    e.v    = s.ev;
    sb.push_back(e);
  endtask

  // Inputs idle, reset pulsed across one full cycle, released at a negedge.
  task automatic do_reset();
    drive("rst_idle", mk(0, 0, 0, 0, 0, 0, 0, NORM));
    void'(sb.pop_front());
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    exp_t e;
    rst_i = 1'b0;
    drive("reset_ctrl", mk(0, 0, 0, 0, 0, 0, 0, NORM));
    #2;
    e = sb.pop_front();
    n_tests++;
    if (ctrl !== e.v) begin
      n_fail++; $display("FAIL %s: got %b want %b", e.name, ctrl, e.v);
    end
    n_tests++;
    if ({stall_cnt_o, flush_cnt_o, timeout_err_o} !== {(2*CNT_W+1){1'b0}}) begin
      n_fail++;
      $display("FAIL reset_state: stall=%0d flush=%0d err=%b want 0/0/0",
               stall_cnt_o, flush_cnt_o, timeout_err_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_load_use();
    stim_t seq[$];
    exp_t  e;
    do_reset();
    seq = '{mk(1, 8, 8, 1, 0, 0, 0, LU),     // bubble inserted
            mk(0, 8, 8, 1, 0, 0, 0, NORM)};  // bubble cleared MemRead
    foreach (seq[i]) begin
      drive($sformatf("load_use[%0d]", i), seq[i]);
      #2;
      e = sb.pop_front();
      n_tests++;
      if (ctrl !== e.v) begin
        n_fail++; $display("FAIL %s: got %b want %b", e.name, ctrl, e.v);
      end
      @(negedge clk_i);
    end
    n_tests++;
    if (stall_cnt_o !== 8'd1) begin
      n_fail++; $display("FAIL load_use_stall_cnt: got %0d want 1", stall_cnt_o);
    end
  endtask

  task automatic test_load_zero();
    stim_t seq[$];
    exp_t  e;
    do_reset();
    seq = '{mk(1, 0, 0, 0, 0, 0, 0, NORM),   // load to $zero: no hazard
            mk(1, 8, 3, 4, 0, 0, 0, NORM),   // no register match
            mk(1, 8, 3, 8, 0, 0, 0, LU),     // match on rt
            mk(0, 8, 8, 8, 0, 0, 0, NORM)};  // not a load
    foreach (seq[i]) begin
      drive($sformatf("load_zero[%0d]", i), seq[i]);
      #2;
      e = sb.pop_front();
      n_tests++;
      if (ctrl !== e.v) begin
        n_fail++; $display("FAIL %s: got %b want %b", e.name, ctrl, e.v);
      end
      @(negedge clk_i);
    end
    n_tests++;
    if (stall_cnt_o !== 8'd1) begin
      n_fail++; $display("FAIL load_zero_stall_cnt: got %0d want 1", stall_cnt_o);
    end
  endtask

  task automatic test_branch();
    stim_t seq[$];
    exp_t  e;
    do_reset();
    seq = '{mk(1, 8, 8, 0, 1, 0, 0, BR),
            mk(0, 0, 0, 0, 0, 0, 0, NORM)};
    foreach (seq[i]) begin
      drive($sformatf("branch[%0d]", i), seq[i]);
      #2;
      e = sb.pop_front();
      n_tests++;
      if (ctrl !== e.v) begin
        n_fail++; $display("FAIL %s: got %b want %b", e.name, ctrl, e.v);
      end
      @(negedge clk_i);
    end
    n_tests++;
    if ({flush_cnt_o, stall_cnt_o} !== {8'd1, 8'd0}) begin
      n_fail++;
      $display("FAIL branch_counters: flush=%0d stall=%0d want 1/0", flush_cnt_o, stall_cnt_o);
    end
  endtask

  task automatic test_mem_wait();
    stim_t seq[$];
    exp_t  e;
    do_reset();
    seq = '{mk(0, 0, 0, 0, 1, 1, 0, FRZ),    // miss in RUN, branch ignored
            mk(1, 8, 8, 0, 0, 1, 0, FRZ),    // load-use ignored while frozen
            mk(0, 0, 0, 0, 0, 1, 0, FRZ),
            mk(0, 0, 0, 0, 1, 1, 1, BR),     // ack cycle: normal rules apply
            mk(0, 0, 0, 0, 0, 0, 0, NORM),
            mk(0, 0, 0, 0, 0, 1, 1, NORM),   // req+ack together in RUN
            mk(0, 0, 0, 0, 0, 0, 0, NORM)};  // still RUN afterwards
    foreach (seq[i]) begin
      drive($sformatf("mem_wait[%0d]", i), seq[i]);
      #2;
      e = sb.pop_front();
      n_tests++;
      if (ctrl !== e.v) begin
        n_fail++; $display("FAIL %s: got %b want %b", e.name, ctrl, e.v);
      end
      @(negedge clk_i);
    end
    n_tests++;
    if ({stall_cnt_o, flush_cnt_o} !== {8'd3, 8'd1}) begin
      n_fail++;
      $display("FAIL mem_wait_counters: stall=%0d flush=%0d want 3/1", stall_cnt_o, flush_cnt_o);
    end
  endtask

  task automatic test_back_to_back();
    stim_t seq[$];
    exp_t  e;
    do_reset();
    seq = '{mk(0, 0, 0, 0, 1, 0, 0, BR),
            mk(1, 5, 5, 0, 0, 0, 0, LU),
            mk(0, 0, 0, 0, 0, 1, 0, FRZ),
            mk(0, 0, 0, 0, 0, 1, 1, NORM),
            mk(0, 0, 0, 0, 0, 0, 0, NORM)};
    foreach (seq[i]) begin
      drive($sformatf("b2b[%0d]", i), seq[i]);
      #2;
      e = sb.pop_front();
      n_tests++;
      if (ctrl !== e.v) begin
        n_fail++; $display("FAIL %s: got %b want %b", e.name, ctrl, e.v);
      end
      @(negedge clk_i);
    end
    n_tests++;
    if ({stall_cnt_o, flush_cnt_o} !== {8'd2, 8'd1}) begin
      n_fail++;
      $display("FAIL b2b_counters: stall=%0d flush=%0d want 2/1", stall_cnt_o, flush_cnt_o);
    end
  endtask

  // Ack withheld for 10 cycles: cycle 1 is the RUN miss, cycles 2..10 are
  // MEM_WAIT. The flag must be low while at most 2 wait cycles have elapsed
  // and high once 4 have completed.
  task automatic test_timeout();
    stim_t seq[$];
    exp_t  e;
    do_reset();
    for (int k = 0; k < 10; k++) seq.push_back(mk(0, 0, 0, 0, 0, 1, 0, FRZ));
    seq.push_back(mk(0, 0, 0, 0, 0, 1, 1, NORM));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, NORM));
    seq.push_back(mk(0, 0, 0, 0, 0, 0, 0, NORM));
    foreach (seq[i]) begin
      drive($sformatf("timeout[%0d]", i), seq[i]);
      #2;
      e = sb.pop_front();
      n_tests++;
      if (ctrl !== e.v) begin
        n_fail++; $display("FAIL %s: got %b want %b", e.name, ctrl, e.v);
      end
      if (i <= 3) begin
        n_tests++;
        if (timeout_err_o !== 1'b0) begin
          n_fail++; $display("FAIL timeout_early[%0d]: err=%b want 0", i, timeout_err_o);
        end
      end else if (i >= 5) begin
        n_tests++;
        if (timeout_err_o !== 1'b1) begin
          n_fail++; $display("FAIL timeout_sticky[%0d]: err=%b want 1", i, timeout_err_o);
        end
      end
      @(negedge clk_i);
    end
    n_tests++;
    if (stall_cnt_o !== 8'd10) begin
      n_fail++; $display("FAIL timeout_stall_cnt: got %0d want 10", stall_cnt_o);
    end
  endtask

  // Enters MEM_WAIT with the error flag still set, then resets mid-cycle with
  // the memory inputs idle: outputs must return to RUN values at once.
  task automatic test_reset_async();
    exp_t e;
    drive("rst_async_miss", mk(0, 0, 0, 0, 0, 1, 0, FRZ));
    #2;
    e = sb.pop_front();
    n_tests++;
    if (ctrl !== e.v) begin
      n_fail++; $display("FAIL %s: got %b want %b", e.name, ctrl, e.v);
    end
    @(negedge clk_i);
    #3;
    drive("rst_async_ctrl", mk(0, 0, 0, 0, 0, 0, 0, NORM));
    rst_i = 1'b0;
    #1;
    e = sb.pop_front();
    n_tests++;
    if (ctrl !== e.v) begin
      n_fail++; $display("FAIL %s: got %b want %b", e.name, ctrl, e.v);
    end
    n_tests++;
    if ({stall_cnt_o, flush_cnt_o, timeout_err_o} !== {(2*CNT_W+1){1'b0}}) begin
      n_fail++;
      $display("FAIL rst_async_state: stall=%0d flush=%0d err=%b want 0/0/0",
               stall_cnt_o, flush_cnt_o, timeout_err_o);
    end
    @(negedge clk_i);
    rst_i = 1'b1;
    drive("rst_async_after", mk(0, 0, 0, 0, 0, 0, 0, NORM));
    #2;
    e = sb.pop_front();
    n_tests++;
    if (ctrl !== e.v) begin
      n_fail++; $display("FAIL %s: got %b want %b", e.name, ctrl, e.v);
    end
    @(negedge clk_i);
  endtask

  task automatic test_saturation();
    exp_t e;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      drive("sat_frz", mk(0, 0, 0, 0, 0, 1, 0, FRZ));
      #2;
      e = sb.pop_front();
      n_tests++;
      if (ctrl !== e.v) begin
        n_fail++; $display("FAIL %s[%0d]: got %b want %b", e.name, i, ctrl, e.v);
      end
      if (i == 100) begin
        n_tests++;
        if (stall_cnt_o !== 8'd100) begin
          n_fail++; $display("FAIL sat_mid: got %0d want 100", stall_cnt_o);
        end
      end
      @(negedge clk_i);
    end
    n_tests++;
    if (stall_cnt_o !== 8'hFF) begin
      n_fail++; $display("FAIL sat_hold: got %0d want 255", stall_cnt_o);
    end
    drive("sat_ack", mk(0, 0, 0, 0, 0, 1, 1, NORM));
    void'(sb.pop_front());
    @(negedge clk_i);
  endtask

  initial begin
    @(negedge clk_i);
    test_reset();
    test_load_use();
    test_load_zero();
    test_branch();
    test_mem_wait();
    test_back_to_back();
    test_timeout();
    test_reset_async();
    test_saturation();
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
